// File: rtl/cordic_ctrl_pkg.sv
// Shared definitions for the CORDIC request controller: FSM states,
// operation encodings and range-reduction region flag values.
package cordic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        ACK   = 3'd3,
        RESP  = 3'd4
    } ctrlState_t;

    localparam logic OP_SINE   = 1'b1;
    localparam logic OP_COSINE = 1'b0;

    localparam logic [1:0] REGION_0 = 2'b00;
    localparam logic [1:0] REGION_1 = 2'b01;
    localparam logic [1:0] REGION_2 = 2'b10;
    localparam logic [1:0] REGION_3 = 2'b11;

endpackage

// File: rtl/cordic_request_controller_if.sv
// Bundles the request/response handshake and the CORDIC start/acknowledge
// handshake. The slave modport is the controller; the master modport is the
// environment (requester, consumer and CORDIC unit together).
interface cordic_request_controller_if #(
    parameter int W = 32
);
    logic         req_valid;
    logic         req_ready;
    logic         req_op;
    logic [W-1:0] req_angle;
    logic [1:0]   req_region;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_ovf;
    logic         rsp_unf;
    logic         rsp_timeout;

    logic         beg_fsm_cordic;
    logic         ack_cordic;
    logic         operation;
    logic [W-1:0] data_in;
    logic [1:0]   shift_region_flag;
    logic         ready_cordic;
    logic [W-1:0] data_output;
    logic         overflow_flag;
    logic         underflow_flag;

    modport slave (
        input  req_valid, req_op, req_angle, req_region,
        output req_ready,
        output rsp_valid, rsp_data, rsp_ovf, rsp_unf, rsp_timeout,
        input  rsp_ready,
        output beg_fsm_cordic, ack_cordic, operation, data_in, shift_region_flag,
        input  ready_cordic, data_output, overflow_flag, underflow_flag
    );

    modport master (
        output req_valid, req_op, req_angle, req_region,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_ovf, rsp_unf, rsp_timeout,
        output rsp_ready,
        input  beg_fsm_cordic, ack_cordic, operation, data_in, shift_region_flag,
        output ready_cordic, data_output, overflow_flag, underflow_flag
    );

endinterface

// File: rtl/cordic_watchdog_counter.sv
// Counts cycles spent waiting on the CORDIC unit. Expire is decoded from the
// count register, so it rises in the TIMEOUT-th enabled cycle after a clear.
module cordic_watchdog_counter #(
    parameter int TW      = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [TW-1:0] r_count;

    // Clear has priority so a fresh operation always starts counting from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign o_expire = (r_count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/cordic_request_controller.sv
// Initiator-side front end for the sine/cosine CORDIC unit: accepts one
// request, pulses the CORDIC start, waits (bounded by a watchdog) for the
// result, acknowledges it and holds the response until it is consumed.
module cordic_request_controller
    import cordic_ctrl_pkg::*;
#(
    parameter int W       = 32,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input logic                        clk,
    input logic                        rst,
    cordic_request_controller_if.slave bus
);

    ctrlState_t   r_state;
    logic         r_reqReady;
    logic         r_beg;
    logic         r_ack;
    logic         r_rspValid;
    logic [W-1:0] r_rspData;
    logic         r_rspOvf;
    logic         r_rspUnf;
    logic         r_rspTimeout;
    logic         r_operation;
    logic [W-1:0] r_dataIn;
    logic [1:0]   r_region;
    logic         r_ovf;
    logic         r_unf;

    logic w_wdClear;
    logic w_wdEnable;
    logic w_wdExpire;

    assign w_wdClear  = (r_state == START);
    assign w_wdEnable = (r_state == WAIT);

    cordic_watchdog_counter #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_wdClear),
        .i_enable (w_wdEnable),
        .o_expire (w_wdExpire)
    );

    // Request/response FSM; every output is a register updated with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_reqReady   <= 1'b1;
            r_beg        <= 1'b0;
            r_ack        <= 1'b0;
            r_rspValid   <= 1'b0;
            r_rspData    <= '0;
            r_rspOvf     <= 1'b0;
            r_rspUnf     <= 1'b0;
            r_rspTimeout <= 1'b0;
            r_operation  <= 1'b0;
            r_dataIn     <= '0;
            r_region     <= 2'b00;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else begin
            r_beg <= 1'b0;
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_operation <= bus.req_op;
                        r_dataIn    <= bus.req_angle;
                        r_region    <= bus.req_region;
                        r_reqReady  <= 1'b0;
                        r_beg       <= 1'b1;
                        r_state     <= START;
                    end
                end
                START: begin
                    r_ovf   <= 1'b0;
                    r_unf   <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_ovf <= r_ovf | bus.overflow_flag;
                    r_unf <= r_unf | bus.underflow_flag;
                    if (bus.ready_cordic) begin
                        r_rspData    <= bus.data_output;
                        r_rspTimeout <= 1'b0;
                        r_ack        <= 1'b1;
                        r_state      <= ACK;
                    end else if (w_wdExpire) begin
                        r_rspData    <= '0;
                        r_rspTimeout <= 1'b1;
                        r_ack        <= 1'b1;
                        r_state      <= ACK;
                    end
                end
                ACK: begin
                    r_rspOvf   <= r_ovf;
                    r_rspUnf   <= r_unf;
                    r_rspValid <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_reqReady <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_reqReady <= 1'b1;
                    r_rspValid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready         = r_reqReady;
    assign bus.beg_fsm_cordic    = r_beg;
    assign bus.ack_cordic        = r_ack;
    assign bus.rsp_valid         = r_rspValid;
    assign bus.rsp_data          = r_rspData;
    assign bus.rsp_ovf           = r_rspOvf;
    assign bus.rsp_unf           = r_rspUnf;
    assign bus.rsp_timeout       = r_rspTimeout;
    assign bus.operation         = r_operation;
    assign bus.data_in           = r_dataIn;
    assign bus.shift_region_flag = r_region;

endmodule

// File: tb/tb_cordic_request_controller.sv
// Self-checking bench for cordic_request_controller: a table of directed
// transactions with hand-computed responses, plus reset sequences.
module tb_cordic_request_controller;
    import cordic_ctrl_pkg::*;

    localparam int W           = 32;
    localparam int TIMEOUT     = 15;
    localparam int TW          = 4;
    localparam int CYCLE_LIMIT = 200;
    localparam int NUM_VEC     = 7;

    typedef struct {
        string        name;
        logic         op;
        logic [W-1:0] angle;
        logic [1:0]   region;
        int           readyCycle;
        logic [W-1:0] result;
        int           ovfCycle;
        int           unfCycle;
        int           stall;
        bit           holdValid;
        logic [W-1:0] expData;
        logic         expOvf;
        logic         expUnf;
        logic         expTimeout;
        int           expRspCycle;
    } vector_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    vector_t vectors [NUM_VEC];
    vector_t afterReset;

    cordic_request_controller_if #(.W(W)) bus ();

    cordic_request_controller #(
        .W       (W),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vector_t makeVector(
        input string name, input logic op, input logic [W-1:0] angle,
        input logic [1:0] region, input int readyCycle, input logic [W-1:0] result,
        input int ovfCycle, input int unfCycle, input int stall, input bit holdValid,
        input logic [W-1:0] expData, input logic expOvf, input logic expUnf,
        input logic expTimeout, input int expRspCycle);
        vector_t v;
        v.name        = name;
        v.op          = op;
        v.angle       = angle;
        v.region      = region;
        v.readyCycle  = readyCycle;
        v.result      = result;
        v.ovfCycle    = ovfCycle;
        v.unfCycle    = unfCycle;
        v.stall       = stall;
        v.holdValid   = holdValid;
        v.expData     = expData;
        v.expOvf      = expOvf;
        v.expUnf      = expUnf;
        v.expTimeout  = expTimeout;
        v.expRspCycle = expRspCycle;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input vector_t v);
        int           begCount   = 0;
        int           begCycle   = -1;
        int           ackCount   = 0;
        int           ackCycle   = -1;
        int           rspCycle   = -1;
        int           hsCycle    = -1;
        bit           overlap    = 0;
        bit           reqStable  = 1;
        bit           reqReadyOk = 1;
        bit           holdOk     = 1;
        bit           done       = 0;
        logic         readyAfter = 1'b0;
        logic         validAfter = 1'b1;
        logic [W-1:0] firstData  = '0;
        logic         firstOvf   = 1'b0;
        logic         firstUnf   = 1'b0;
        logic         firstTo    = 1'b0;
        bit           rdy;

        @(negedge clk);
        checkOutput({v.name, " req_ready in idle"}, bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_op     = v.op;
        bus.req_angle  = v.angle;
        bus.req_region = v.region;
        bus.rsp_ready  = 1'b0;

        for (int c = 1; c <= CYCLE_LIMIT && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (v.holdValid) begin
                    bus.req_op     = ~v.op;
                    bus.req_angle  = 32'hDEAD_BEEF;
                    bus.req_region = ~v.region;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (hsCycle > 0) begin
                readyAfter = bus.req_ready;
                validAfter = bus.rsp_valid;
                done       = 1;
            end else begin
                if (bus.beg_fsm_cordic) begin
                    begCount++;
                    if (begCycle < 0) begCycle = c;
                end
                if (bus.ack_cordic) begin
                    ackCount++;
                    if (ackCycle < 0) ackCycle = c;
                end
                if (bus.beg_fsm_cordic && bus.ack_cordic) overlap = 1;
                if (bus.req_ready !== 1'b0) reqReadyOk = 0;
                if (bus.operation !== v.op || bus.data_in !== v.angle ||
                    bus.shift_region_flag !== v.region) reqStable = 0;
                if (bus.rsp_valid) begin
                    if (rspCycle < 0) begin
                        rspCycle  = c;
                        firstData = bus.rsp_data;
                        firstOvf  = bus.rsp_ovf;
                        firstUnf  = bus.rsp_unf;
                        firstTo   = bus.rsp_timeout;
                    end else if (bus.rsp_data !== firstData || bus.rsp_ovf !== firstOvf ||
                                 bus.rsp_unf !== firstUnf || bus.rsp_timeout !== firstTo) begin
                        holdOk = 0;
                    end
                    if (c >= rspCycle + v.stall) begin
                        bus.rsp_ready = 1'b1;
                        bus.req_valid = 1'b0;
                        hsCycle       = c;
                    end
                end
                rdy = (v.readyCycle != 0) && (c >= v.readyCycle) && (ackCount == 0);
                bus.ready_cordic   = rdy;
                bus.data_output    = rdy ? v.result : 32'hFFFF_FFFF;
                bus.overflow_flag  = (c == v.ovfCycle);
                bus.underflow_flag = (c == v.unfCycle);
            end
        end

        bus.rsp_ready      = 1'b0;
        bus.req_valid      = 1'b0;
        bus.ready_cordic   = 1'b0;
        bus.overflow_flag  = 1'b0;
        bus.underflow_flag = 1'b0;

        checkOutput({v.name, " completed"}, done, 1);
        checkOutput({v.name, " beg count"}, begCount, 1);
        checkOutput({v.name, " beg cycle"}, begCycle, 1);
        checkOutput({v.name, " ack count"}, ackCount, 1);
        checkOutput({v.name, " ack cycle"}, ackCycle, v.expRspCycle - 1);
        checkOutput({v.name, " rsp_valid cycle"}, rspCycle, v.expRspCycle);
        checkOutput({v.name, " rsp_data"}, firstData, v.expData);
        checkOutput({v.name, " rsp_ovf"}, firstOvf, v.expOvf);
        checkOutput({v.name, " rsp_unf"}, firstUnf, v.expUnf);
        checkOutput({v.name, " rsp_timeout"}, firstTo, v.expTimeout);
        checkOutput({v.name, " beg/ack overlap"}, overlap, 0);
        checkOutput({v.name, " latched request stable"}, reqStable, 1);
        checkOutput({v.name, " req_ready low while busy"}, reqReadyOk, 1);
        checkOutput({v.name, " response held"}, holdOk, 1);
        checkOutput({v.name, " req_ready after handshake"}, readyAfter, 1);
        checkOutput({v.name, " rsp_valid after handshake"}, validAfter, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " req_ready"}, bus.req_ready, 1);
        checkOutput({tag, " beg_fsm_cordic"}, bus.beg_fsm_cordic, 0);
        checkOutput({tag, " ack_cordic"}, bus.ack_cordic, 0);
        checkOutput({tag, " rsp_valid"}, bus.rsp_valid, 0);
        checkOutput({tag, " rsp_data"}, bus.rsp_data, 0);
        checkOutput({tag, " rsp_ovf"}, bus.rsp_ovf, 0);
        checkOutput({tag, " rsp_unf"}, bus.rsp_unf, 0);
        checkOutput({tag, " rsp_timeout"}, bus.rsp_timeout, 0);
        checkOutput({tag, " operation"}, bus.operation, 0);
        checkOutput({tag, " data_in"}, bus.data_in, 0);
        checkOutput({tag, " shift_region_flag"}, bus.shift_region_flag, 0);
    endtask

    // Main sequence: reset, vector table, asynchronous reset mid-WAIT, recovery.
    initial begin
        checks = 0;
        errors = 0;

        vectors[0] = makeVector("sine_pi6", OP_SINE, 32'h3F06_0A92, REGION_0, 12, 32'h3F00_0000,
                                0, 0, 0, 0, 32'h3F00_0000, 0, 0, 0, 14);
        vectors[1] = makeVector("cosine_hold", OP_COSINE, 32'h3F49_0FDB, REGION_2, 6, 32'h3F35_04F3,
                                0, 0, 0, 1, 32'h3F35_04F3, 0, 0, 0, 8);
        vectors[2] = makeVector("timeout", OP_SINE, 32'h3FC9_0FDB, REGION_1, 0, 32'h3F80_0000,
                                0, 7, 0, 0, 32'h0000_0000, 0, 1, 1, TIMEOUT + 3);
        vectors[3] = makeVector("ready_at_expiry", OP_COSINE, 32'h3E80_0000, REGION_3, TIMEOUT + 1,
                                32'h3F78_0000, 0, 0, 0, 0, 32'h3F78_0000, 0, 0, 0, TIMEOUT + 3);
        vectors[4] = makeVector("overflow", OP_SINE, 32'h4049_0FDB, REGION_0, 10, 32'h3F00_0001,
                                5, 0, 0, 0, 32'h3F00_0001, 1, 0, 0, 12);
        vectors[5] = makeVector("clean_after_ovf", OP_SINE, 32'h3F00_0000, REGION_0, 3, 32'h3EF5_7744,
                                0, 0, 0, 0, 32'h3EF5_7744, 0, 0, 0, 5);
        vectors[6] = makeVector("min_latency_stall", OP_COSINE, 32'h3DCC_CCCD, REGION_1, 2,
                                32'h3F7E_B852, 0, 2, 20, 0, 32'h3F7E_B852, 0, 1, 0, 4);
        afterReset = makeVector("after_reset", OP_SINE, 32'h3F06_0A92, REGION_2, 4, 32'h3F00_0000,
                                0, 0, 0, 0, 32'h3F00_0000, 0, 0, 0, 6);

        bus.req_valid      = 1'b0;
        bus.req_op         = 1'b0;
        bus.req_angle      = '0;
        bus.req_region     = 2'b00;
        bus.rsp_ready      = 1'b0;
        bus.ready_cordic   = 1'b0;
        bus.data_output    = '0;
        bus.overflow_flag  = 1'b0;
        bus.underflow_flag = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;

        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(vectors[i]);
        end

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_SINE;
        bus.req_angle  = 32'h4000_0000;
        bus.req_region = REGION_1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("mid_reset beg in cycle 1", bus.beg_fsm_cordic, 1);
        repeat (3) @(negedge clk);
        checkOutput("mid_reset data_in latched", bus.data_in, 32'h4000_0000);
        #2 rst = 1'b0;
        #1;
        checkResetValues("mid_reset async");
        repeat (2) @(negedge clk);
        checkOutput("mid_reset held ack", bus.ack_cordic, 0);
        checkOutput("mid_reset held req_ready", bus.req_ready, 1);
        rst = 1'b1;

        applyStimulus(afterReset);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
